// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: round controller for the iterative AES-128/192/256 encryption datapath
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort back to IDLE
//   in_valid/in_ready   plaintext handshake, in_data captured into pt_q
//   mux_sel, mux_out    select to / result from the 3:1 state mux (00 idle, 01 init, 10 mid, 11 final)
//   state_q, round_idx  state register and round-key index for the datapath
//   busy                high while a block is in flight (LOAD/ROUND/FINAL)
//   out_valid/out_ready ciphertext handshake, out_data is state_q
module aes_round_sequencer #(
    parameter int NR = 10,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] pt_q,
    output logic [1:0]    mux_sel,
    input  logic [DW-1:0] mux_out,
    output logic [DW-1:0] state_q,
    output logic [3:0]    round_idx,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
    localparam logic [3:0] LAST_MID = 4'(NR - 1);
    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_round_sequencer: NR must be 10, 12 or 14");
        end
    endgenerate
    state_t state, state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? LOAD : IDLE;
            LOAD:    state_n = ROUND;
            ROUND:   state_n = (round_idx == LAST_MID) ? FINAL : ROUND;
            FINAL:   state_n = DONE;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
        if (flush)
            state_n = IDLE;
    end
    // Datapath registers share the FSM's reset; flush freezes pt_q/state_q and clears the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pt_q      <= '0;
            state_q   <= '0;
            round_idx <= '0;
        end else begin
            state <= state_n;
            if (flush) begin
                round_idx <= '0;
            end else begin
                if (state == IDLE && in_valid) begin
                    pt_q      <= in_data;
                    round_idx <= '0;
                end
                if (busy)
                    state_q <= mux_out;
                if (state == LOAD || state == ROUND)
                    round_idx <= round_idx + 4'd1;
            end
        end
    end
    // Select is a pure decode of the state register, so it never depends on mux_out.
    assign mux_sel   = state == LOAD ? 2'b01 : state == ROUND ? 2'b10 : state == FINAL ? 2'b11 : 2'b00;
    assign busy      = state == LOAD || state == ROUND || state == FINAL;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_data  = state_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed and randomized checks of the round sequencer against an AES-128 reference
module tb_aes_round_sequencer;
    localparam int NR = 10;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, flush, in_valid, in_ready, busy, out_valid, out_ready;
    logic [127:0] in_data, pt_q, mux_out, state_q, out_data;
    logic [1:0] mux_sel;
    logic [3:0] round_idx;
    logic flush14, in_valid14, in_ready14, busy14, out_valid14, out_ready14;
    logic [127:0] in_data14, pt_q14, mux_out14, state_q14, out_data14;
    logic [1:0] mux_sel14;
    logic [3:0] round_idx14;
    logic [127:0] rk [0:15];
    int npass = 0, nchk = 0, nfail = 0;

    aes_round_sequencer #(.NR(NR), .DW(128)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .pt_q(pt_q), .mux_sel(mux_sel), .mux_out(mux_out), .state_q(state_q),
        .round_idx(round_idx), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data));

    aes_round_sequencer #(.NR(14), .DW(128)) dut14 (
        .clk(clk), .rst_n(rst_n), .flush(flush14), .in_valid(in_valid14), .in_ready(in_ready14),
        .in_data(in_data14), .pt_q(pt_q14), .mux_sel(mux_sel14), .mux_out(mux_out14), .state_q(state_q14),
        .round_idx(round_idx14), .busy(busy14), .out_valid(out_valid14), .out_ready(out_ready14),
        .out_data(out_data14));

    // Counting datapath for the NR=14 instance: load pt, then +1 per round.
    assign mux_out14 = mux_sel14 == 2'b01 ? pt_q14 : state_q14 + 128'd1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xt(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] p, r;
        p = v;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gm(p, p);
            r = gm(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] rnd(input logic [127:0] s, input logic [127:0] k, input bit last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) b[r+4*c] = t[r+4*c];
            end else begin
                b[4*c]   = gm(8'h02, t[4*c]) ^ gm(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                b[4*c+1] = t[4*c] ^ gm(8'h02, t[4*c+1]) ^ gm(8'h03, t[4*c+2]) ^ t[4*c+3];
                b[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(8'h02, t[4*c+2]) ^ gm(8'h03, t[4*c+3]);
                b[4*c+3] = gm(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gm(8'h02, t[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    task automatic keyexp(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = r <= NR ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    function automatic logic [127:0] enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r < NR; r++) s = rnd(s, rk[r], 1'b0);
        return rnd(s, rk[NR], 1'b1);
    endfunction

    // AES datapath behind the state mux, settled on the falling edge before each rising edge.
    always @(negedge clk)
        mux_out = mux_sel == 2'b01 ? pt_q ^ rk[0] :
                  mux_sel == 2'b10 ? rnd(state_q, rk[round_idx], 1'b0) :
                  mux_sel == 2'b11 ? rnd(state_q, rk[round_idx], 1'b1) : '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk(tag, {in_ready, busy, out_valid, mux_sel, round_idx}, {1'b1, 1'b0, 1'b0, 2'b00, 4'd0});
        chk({tag, "_pt"}, pt_q, '0);
        chk({tag, "_st"}, state_q, '0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One block end to end: trace check per cycle, ciphertext at cycle NR+2, hold under backpressure.
    task automatic run(input logic [127:0] pt, input int hold, input bit junk);
        logic [127:0] exp;
        logic [1:0] es;
        logic [3:0] ei;
        exp = enc(pt);
        chk("idle_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data = pt;
        @(negedge clk);
        in_valid = junk;
        in_data = ~pt;
        for (int c = 1; c <= NR + 1; c++) begin
            es = c == 1 ? 2'b01 : c == NR + 1 ? 2'b11 : 2'b10;
            ei = c == 1 ? 4'd0 : c == NR + 1 ? 4'(NR) : 4'(c - 1);
            chk("trace", {mux_sel, round_idx, busy, in_ready, out_valid}, {es, ei, 3'b100});
            if (c == 1) chk("pt_q", pt_q, pt);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("done_flags", {out_valid, in_ready, busy, mux_sel}, 5'b10000);
        chk("ciphertext", out_data, exp);
        chk("pt_kept", pt_q, pt);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_flags", {out_valid, in_ready}, 2'b10);
            chk("hold_data", out_data, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("released", {in_ready, out_valid, busy, mux_sel}, 5'b10000);
    endtask

    initial begin
        logic [127:0] pt;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush14 = 1'b0; in_valid14 = 1'b0; in_data14 = '0; out_ready14 = 1'b0;
        keyexp(128'h000102030405060708090a0b0c0d0e0f);
        #1;
        chk_rst("reset");
        chk("fips_ref", enc(128'h00112233445566778899aabbccddeeff), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(128'h00112233445566778899aabbccddeeff, 20, 1'b0);
        run(rand128(), 2, 1'b1);
        // flush at cycle 5
        pt = rand128();
        in_valid = 1'b1;
        in_data = pt;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {in_ready, busy, out_valid, mux_sel, round_idx}, {1'b1, 1'b0, 1'b0, 2'b00, 4'd0});
        chk("flush_pt", pt_q, pt);
        for (int i = 0; i < NR + 3; i++) begin
            @(negedge clk);
            chk("flush_noout", {out_valid, in_ready}, 2'b01);
        end
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = ~pt;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_prio", {in_ready, busy}, 2'b10);
        chk("flush_prio_pt", pt_q, pt);
        run(rand128(), 1, 1'b0);
        // asynchronous reset at cycle 7
        in_valid = 1'b1;
        in_data = rand128();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_rst("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_noout", {out_valid, in_ready}, 2'b01);
        run(rand128(), 0, 1'b0);
        for (int k = 0; k < 5; k++) run(rand128(), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        // NR=14 select trace on the counting datapath
        pt = rand128();
        in_valid14 = 1'b1;
        in_data14 = pt;
        @(negedge clk);
        in_valid14 = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chk("trace14", {mux_sel14, round_idx14, busy14, out_valid14},
                {c == 1 ? 2'b01 : c == 15 ? 2'b11 : 2'b10, c == 1 ? 4'd0 : c == 15 ? 4'd14 : 4'(c - 1), 2'b10});
            @(negedge clk);
        end
        chk("done14", {out_valid14, in_ready14, busy14}, 3'b100);
        chk("data14", out_data14, pt + 128'd14);
        out_ready14 = 1'b1;
        @(negedge clk);
        out_ready14 = 1'b0;
        chk("released14", {in_ready14, out_valid14}, 2'b10);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
